sobel_window_engine: RTL and testbench
======================================

Name: sobel_window_engine

Overview:
- Streaming 3x3 Sobel stage between the grayscale memory read-out and the Gx/Gy result memories.
- Accepts 4-bit gray pixels in row-major order, one per pix_valid, and holds two line buffers plus a 3x3 window.
- Emits |Gx| and |Gy|, scaled to 4 bits, with the write address of the window centre, so the results can be written straight into the gradient memories.

Parameters:
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.
- PIX_W, 4, gray pixel and output width.
- ADDR_W, 10, address width; must hold IMG_W*IMG_H-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- pix_valid  in  1  pix_in is valid this cycle; ignored outside RUN.
- pix_in  in  PIX_W  gray pixel.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  one-cycle write strobe for the result.
- out_addr  out  ADDR_W  centre address, row*IMG_W+col.
- gx_out  out  PIX_W  |Gx|>>2.
- gy_out  out  PIX_W  |Gy|>>2.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: state=IDLE; all outputs 0; row/col counters and window registers 0. Line-buffer contents need not be cleared.
- States: IDLE -> RUN -> DRAIN -> (BORDER if macro) -> DONE -> IDLE.
- IDLE:
  - start=1 -> RUN next edge; counters cleared to row=0, col=0.
  - start is ignored in all other states.
- RUN:
  - Each edge with pix_valid=1 accepts pix_in as pixel (row,col), shifts the line buffers and window, and advances col.
  - col wraps IMG_W-1 -> 0 and increments row.
  - Gaps in pix_valid are allowed; nothing advances without it.
- Window and output timing:
  - When pixel (r,c) with r>=2 and c>=2 is accepted, the window holds rows r-2..r, cols c-2..c.
  - On the next edge, register: out_valid=1, out_addr=(r-1)*IMG_W+(c-1), gx_out, gy_out.
  - out_valid is high for exactly one cycle per interior centre: (IMG_W-2)*(IMG_H-2)=900 strobes at defaults.
  - Windows straddling a row wrap (c<2) produce no output.
- Arithmetic, with pRC the window element at row R, col C, 0 = oldest:
  - Gx=(p02+2p12+p22)-(p00+2p10+p20), signed, 7 bits minimum (range ±60).
  - Gy=(p20+2p21+p22)-(p00+2p01+p02).
  - Output = |G|>>2. The maximum 60 maps to 15, so no saturation is needed, but the implementation clamps to 2^PIX_W-1 anyway.
- Frame end:
  - After the last pixel (IMG_H-1,IMG_W-1) is accepted -> DRAIN.
  - DRAIN lasts one cycle, during which the final out_valid is emitted; then -> DONE (or BORDER).
- DONE: done=1 for one cycle, busy=1; then -> IDLE with busy=0.
- Events in the same cycle:
  - out_valid and done are never high in the same cycle.
  - pix_valid in DRAIN/DONE/BORDER is ignored.
- rst mid-frame: returns to IDLE on the same edge and drops any pending out_valid. The next frame's outputs are unaffected by stale window data, because output is gated on row>=2 and col>=2 of the new frame.

Optional Feature:
- Macro: SOBEL_CLEAR_BORDER_EN.
- Defined:
  - After DRAIN, enter BORDER.
  - Emit one out_valid per border address (row 0, row IMG_H-1, col 0, col IMG_W-1) in ascending address order, one per cycle, with gx_out=gy_out=0.
  - At defaults this is 124 writes; then -> DONE.
  - Total strobes per frame = IMG_W*IMG_H.
- Undefined: the BORDER state does not exist, and border addresses are never written.

Test Plan:
- Flat image, all pixels 5, pix_valid continuous -> 900 strobes, all gx=gy=0; first out_addr=33, last=990; done 2 cycles after the last pixel accepted.
- Vertical step, cols 0-15 =0 and cols 16-31 =15 -> gx_out=15 at cols 15 and 16, 0 elsewhere; gy_out=0 everywhere.
- Horizontal step, rows 0-15 =0 and rows 16-31 =15 -> gy_out=15 at rows 15 and 16, 0 elsewhere; gx_out=0.
- Same vertical-step image with pix_valid toggling 1,0,0 pattern -> identical (addr,gx,gy) sequence to the continuous case.
- rst asserted after pixel 500, then start and a fresh flat-9 frame -> 900 strobes all 0; no strobe during or after reset before row 2.
- With SOBEL_CLEAR_BORDER_EN, flat image -> 1024 strobes total; the last 124 are border addresses 0..31, 32, 63, ..., 992..1023 ascending, all with value 0; then done.

Source files
------------

// File: rtl/sobel_window_engine.sv
// Streaming 3x3 Sobel stage: two line buffers feed a 3x3 window; emits |Gx|>>2, |Gy|>>2 per interior centre.
// Optional macro SOBEL_CLEAR_BORDER_EN adds a BORDER state that writes zeros to every border address.
module sobel_window_engine #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_in,
  output logic              busy,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  gx_out,
  output logic [PIX_W-1:0]  gy_out,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = PIX_W + 2;
  localparam int GW = PIX_W + 4;
  localparam logic [GW-1:0] MAXV = GW'((1 << PIX_W) - 1);

`ifdef SOBEL_CLEAR_BORDER_EN
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, BORDER, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

  state_t state;

  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [PIX_W-1:0]  lb_top [IMG_W];
  logic [PIX_W-1:0]  lb_mid [IMG_W];
  logic [PIX_W-1:0]  win [3][3];
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              accept;
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;

`ifdef SOBEL_CLEAR_BORDER_EN
  logic [ADDR_W-1:0] baddr;
  logic [CW-1:0]     bcol;
  logic              edge_row;
`endif

  assign accept = (state == RUN) && pix_valid;

  function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [PIX_W-1:0] scale(input logic signed [GW-1:0] g);
    logic [GW-1:0] m;
    m = g[GW-1] ? GW'(-g) : GW'(g);
    m = m >> 2;
    return (m > MAXV) ? '1 : m[PIX_W-1:0];
  endfunction

  // Column [0] is the oldest column, row [0] the oldest row.
  always_comb begin
    gx = '0;
    gy = '0;
    gx = $signed(GW'(wsum(win[0][2], win[1][2], win[2][2])))
       - $signed(GW'(wsum(win[0][0], win[1][0], win[2][0])));
    gy = $signed(GW'(wsum(win[2][0], win[2][1], win[2][2])))
       - $signed(GW'(wsum(win[0][0], win[0][1], win[0][2])));
  end

  // Line buffers are indexed by column: mid holds the previous row, top the one before.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix_in;
    end
  end

`ifdef SOBEL_CLEAR_BORDER_EN
  assign edge_row = (baddr < ADDR_W'(IMG_W)) || (baddr >= ADDR_W'((IMG_H - 1) * IMG_W));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      win       <= '{default: '0};
      pend      <= 1'b0;
      pend_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      gx_out    <= '0;
      gy_out    <= '0;
`ifdef SOBEL_CLEAR_BORDER_EN
      baddr     <= '0;
      bcol      <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      pend      <= 1'b0;
      // The window is stable until the next accept, so the result registers one edge after it.
      if (pend) begin
        out_valid <= 1'b1;
        out_addr  <= pend_addr;
        gx_out    <= scale(gx);
        gy_out    <= scale(gy);
      end
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (pix_valid) begin
            win[0][0] <= win[0][1];
            win[0][1] <= win[0][2];
            win[0][2] <= lb_top[col];
            win[1][0] <= win[1][1];
            win[1][1] <= win[1][2];
            win[1][2] <= lb_mid[col];
            win[2][0] <= win[2][1];
            win[2][1] <= win[2][2];
            win[2][2] <= pix_in;
            pend      <= (row >= RW'(2)) && (col >= CW'(2));
            pend_addr <= ADDR_W'((int'(row) - 1) * IMG_W + int'(col) - 1);
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              if (row == RW'(IMG_H - 1)) state <= DRAIN;
              else row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          busy <= 1'b1;
`ifdef SOBEL_CLEAR_BORDER_EN
          state <= BORDER;
          baddr <= '0;
          bcol  <= '0;
`else
          state <= DONE;
`endif
        end
`ifdef SOBEL_CLEAR_BORDER_EN
        BORDER: begin
          busy      <= 1'b1;
          out_valid <= 1'b1;
          out_addr  <= baddr;
          gx_out    <= '0;
          gy_out    <= '0;
          if (baddr == ADDR_W'(IMG_W * IMG_H - 1)) begin
            state <= DONE;
          end else if (edge_row || bcol == CW'(IMG_W - 1)) begin
            baddr <= baddr + 1'b1;
            bcol  <= (bcol == CW'(IMG_W - 1)) ? '0 : bcol + 1'b1;
          end else begin
            // Interior rows: jump straight from column 0 to the last column.
            baddr <= baddr + ADDR_W'(IMG_W - 1);
            bcol  <= CW'(IMG_W - 1);
          end
        end
`endif
        DONE: begin
          busy  <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_engine.sv
// Self-checking bench for sobel_window_engine: directed and random frames against an image-level Sobel model.
module tb_sobel_window_engine;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int PW = 4;
  localparam int AW = 10;
  localparam int NB = 2 * W + 2 * (H - 2);
`ifdef SOBEL_CLEAR_BORDER_EN
  localparam int DONE_LAT  = 2 + NB;
  localparam int LAST_ADDR = W * H - 1;
`else
  localparam int DONE_LAT  = 2;
  localparam int LAST_ADDR = (H - 2) * W + (W - 2);
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [PW-1:0] pix_in;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [PW-1:0] gx_out;
  logic [PW-1:0] gy_out;
  logic          done;

  int total = 0;
  int bad   = 0;
  int img [H][W];
  logic [AW+2*PW-1:0] got [$];
  logic [AW+2*PW-1:0] exp_q [$];
  bit overlap;

  sobel_window_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .busy(busy), .out_valid(out_valid), .out_addr(out_addr),
    .gx_out(gx_out), .gy_out(gy_out), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) got.push_back({out_addr, gx_out, gy_out});
    if (out_valid && done) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int mag(input int g);
    int m;
    m = (g < 0) ? -g : g;
    m = m / 4;
    return (m > (1 << PW) - 1) ? (1 << PW) - 1 : m;
  endfunction

  task automatic set_img(input int kind, input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = v;
          1: img[r][c] = (c >= W / 2) ? 15 : 0;
          2: img[r][c] = (r >= H / 2) ? 15 : 0;
          3: img[r][c] = int'($urandom_range(0, 15));
          default: img[r][c] = int'($urandom_range(0, 1)) * 15;
        endcase
  endtask

  // Sobel over the whole image in raster order, written straight from the kernel definition.
  task automatic build_exp();
    int gx, gy;
    exp_q.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        exp_q.push_back({AW'(r * W + c), PW'(mag(gx)), PW'(mag(gy))});
      end
`ifdef SOBEL_CLEAR_BORDER_EN
    for (int a = 0; a < W * H; a++)
      if (a < W || a >= (H - 1) * W || a % W == 0 || a % W == W - 1)
        exp_q.push_back({AW'(a), PW'(0), PW'(0)});
`endif
  endtask

  task automatic feed(input int r, input int c, input int gap_mode);
    int k;
    k = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < k; i++) begin
      pix_valid = 1'b0;
      pix_in    = PW'($urandom);
      if (gap_mode == 2) start = 1'($urandom);
      @(negedge clk);
    end
    start     = 1'b0;
    pix_valid = 1'b1;
    pix_in    = PW'(img[r][c]);
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int gap_mode, input bit noisy);
    int n;
    bit ok;
    build_exp();
    got.delete();
    overlap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_run"}, 32'(busy), 1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) feed(r, c, gap_mode);
    pix_valid = noisy;
    n = 0;
    do begin
      if (noisy) pix_in = PW'($urandom);
      @(negedge clk);
      n++;
    end while (!done && n < DONE_LAT + 50);
    check({name, "_done_latency"}, 32'(n), 32'(DONE_LAT));
    check({name, "_busy_at_done"}, 32'(busy), 1);
    pix_valid = 1'b0;
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 0);
    check({name, "_busy_idle"}, 32'(busy), 0);
    check({name, "_strobes"}, 32'(got.size()), 32'(exp_q.size()));
    check({name, "_overlap"}, 32'(overlap), 0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      ok = (got[i] === exp_q[i]);
      check({name, "_entry"}, 32'(got[i]), 32'(exp_q[i]));
      if (!ok) break;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_gx", 32'(gx_out), 0);
    check("rst_gy", 32'(gy_out), 0);
    rst = 1'b0;
    @(negedge clk);

    set_img(0, 5);
    run_frame("flat5", 0, 1'b0);
    if (got.size() > 0) begin
      check("flat5_first_addr", 32'(got[0][2*PW +: AW]), 33);
      check("flat5_last_addr", 32'(got[got.size()-1][2*PW +: AW]), 32'(LAST_ADDR));
    end

    set_img(1, 0);
    run_frame("vstep", 0, 1'b0);
    run_frame("vstep_gap", 1, 1'b0);
    set_img(2, 0);
    run_frame("hstep", 0, 1'b0);
    set_img(3, 0);
    run_frame("rand", 2, 1'b1);
    set_img(4, 0);
    run_frame("rand_bin", 0, 1'b1);

    // Abort a frame after 500 pixels, then a clean flat-9 frame.
    set_img(3, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) feed(i / W, i % W, 2);
    rst = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    repeat (3) @(negedge clk);
    check("abort_quiet", 32'(got.size()), 0);
    set_img(0, 9);
    run_frame("flat9", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
